// File: rtl/crc_frame_source_pkg.sv
// Shared CRC-8 constants, frame-source state encoding and the byte-wise
// CRC update used by both the RTL and checker-side models.
package crc_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic [2:0] {
        COLLECT,
        DROP,
        SEND_COUNT,
        SEND_DATA,
        SEND_CRC
    } state_e;

    // MSB-first CRC-8, no reflection, no final XOR.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc,
                                               input logic [7:0] data_byte);
        logic [7:0] c;
        c = crc ^ data_byte;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_frame_source_if.sv
// Upstream byte channel, count channel, data channel and the overflow flag.
// master is the frame source itself, slave is its environment.
interface crc_frame_source_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;

    logic       count_valid;
    logic       count_ready;
    logic [7:0] count_data;

    logic       data_valid;
    logic       data_ready;
    logic [7:0] data_data;

    logic       err_overflow;

    modport master (
        input  in_valid, in_data, in_last, count_ready, data_ready,
        output in_ready, count_valid, count_data, data_valid, data_data,
               err_overflow
    );

    modport slave (
        output in_valid, in_data, in_last, count_ready, data_ready,
        input  in_ready, count_valid, count_data, data_valid, data_data,
               err_overflow
    );

endinterface

// File: rtl/crc_frame_source_frame_buffer.sv
// Single-frame byte store: one synchronous write port, one asynchronous
// read port.
module frame_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem_q [DEPTH];

    // NOTE: storage is deliberately not reset; a byte is only read after the
    // same frame has written it, and a reset network here costs a lot of area.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/crc_frame_source.sv
// Collects a byte stream into frames while computing CRC-8, then replays
// count, payload and CRC to the downstream checker.
module crc_frame_source
    import crc_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    crc_frame_source_if.master  bus
);

    localparam int               IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       crc_q, crc_d;
    logic             err_overflow_q, err_overflow_d;
    logic             in_ready_q, count_valid_q, data_valid_q;

    logic             in_accept, count_xfer, data_xfer, wr_en;
    logic [7:0]       rd_data;

    assign in_accept  = bus.in_valid && in_ready_q;
    assign count_xfer = count_valid_q && bus.count_ready;
    assign data_xfer  = data_valid_q && bus.data_ready;
    assign wr_en      = in_accept && (state_q == COLLECT) && (len_q != LEN_MAX);

    frame_buffer #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (IDX_W)
    ) u_frame_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (len_q[IDX_W-1:0]),
        .wr_data (bus.in_data),
        .rd_addr (rd_ptr_q[IDX_W-1:0]),
        .rd_data (rd_data)
    );

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        rd_ptr_d       = rd_ptr_q;
        crc_d          = crc_q;
        err_overflow_d = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (in_accept) begin
                    if (len_q == LEN_MAX) begin
                        err_overflow_d = 1'b1;
                        len_d          = '0;
                        crc_d          = CRC8_INIT;
                        state_d        = bus.in_last ? COLLECT : DROP;
                    end else begin
                        len_d = len_q + LEN_W'(1);
                        crc_d = crc8_update(crc_q, bus.in_data);
                        if (bus.in_last) begin
                            state_d = SEND_COUNT;
                        end
                    end
                end
            end
            DROP: begin
                if (in_accept && bus.in_last) begin
                    state_d = COLLECT;
                end
            end
            SEND_COUNT: begin
                if (count_xfer) begin
                    rd_ptr_d = '0;
                    state_d  = SEND_DATA;
                end
            end
            SEND_DATA: begin
                if (data_xfer) begin
                    rd_ptr_d = rd_ptr_q + LEN_W'(1);
                    if (rd_ptr_q == len_q - LEN_W'(1)) begin
                        state_d = SEND_CRC;
                    end
                end
            end
            SEND_CRC: begin
                if (data_xfer) begin
                    len_d   = '0;
                    crc_d   = CRC8_INIT;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Handshake flags are decoded from the next state so they are plain
    // flops; in_ready stays low while reset is held and rises one edge later.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= COLLECT;
            len_q          <= '0;
            rd_ptr_q       <= '0;
            crc_q          <= CRC8_INIT;
            err_overflow_q <= 1'b0;
            in_ready_q     <= 1'b0;
            count_valid_q  <= 1'b0;
            data_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            rd_ptr_q       <= rd_ptr_d;
            crc_q          <= crc_d;
            err_overflow_q <= err_overflow_d;
            in_ready_q     <= (state_d == COLLECT) || (state_d == DROP);
            count_valid_q  <= (state_d == SEND_COUNT);
            data_valid_q   <= (state_d == SEND_DATA) || (state_d == SEND_CRC);
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.count_valid  = count_valid_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.err_overflow = err_overflow_q;
    assign bus.count_data   = (state_q == SEND_COUNT) ? 8'(len_q) : 8'h00;
    assign bus.data_data    = (state_q == SEND_CRC)  ? crc_q   :
                              (state_q == SEND_DATA) ? rd_data : 8'h00;

endmodule

// File: tb/tb_crc_frame_source.sv
// Directed bench for crc_frame_source: table of frames with hand-computed
// CRCs, plus backpressure, overflow and mid-drain reset sequences.
module tb_crc_frame_source;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    crc_frame_source_if bus();

    crc_frame_source #(.MAX_LEN(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         n;
        logic [7:0] b [20];
        logic [7:0] crc;
    } vec_t;

    vec_t vecs [5];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   emit_cnt = 0;
    int   err_cnt  = 0;
    int   err_cyc  = -1;
    int   acc_cyc [20];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.count_valid || bus.data_valid) emit_cnt++;
        if (bus.err_overflow) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame; returns at the negedge after the last byte is taken.
    task automatic push_frame(input logic [7:0] b [20], input int n);
        int wait_cnt;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = b[i];
            bus.in_last  = (i == n - 1);
            wait_cnt = 0;
            while (bus.in_ready !== 1'b1 && wait_cnt < 100) begin
                @(negedge clk);
                wait_cnt++;
            end
            if (wait_cnt >= 100) begin
                check("push_in_ready", {31'd0, bus.in_ready}, 32'd1);
                break;
            end
            @(negedge clk);
            acc_cyc[i] = cyc;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // With readies high: count at N+1, payload N+2.., CRC, then in_ready.
    task automatic drain_fast(input vec_t v);
        check("count_valid", {31'd0, bus.count_valid}, 32'd1);
        check("count_data", {24'd0, bus.count_data}, v.n);
        check("in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            check("data_valid", {31'd0, bus.data_valid}, 32'd1);
            check($sformatf("data_byte%0d", i), {24'd0, bus.data_data}, {24'd0, v.b[i]});
        end
        @(negedge clk);
        check("crc_valid", {31'd0, bus.data_valid}, 32'd1);
        check("crc_byte", {24'd0, bus.data_data}, {24'd0, v.crc});
        @(negedge clk);
        check("after_crc_valid", {31'd0, bus.data_valid}, 32'd0);
        check("after_crc_in_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] bp_exp [4];
        int         idx;
        logic       cr, dr;

        vecs[0].n = 1; vecs[0].b[0] = 8'hFF; vecs[0].crc = 8'hF3;
        vecs[1].n = 9; vecs[1].crc = 8'hF4;
        for (int i = 0; i < 9; i++) vecs[1].b[i] = 8'h31 + 8'(i);
        vecs[2].n = 1; vecs[2].b[0] = 8'h01; vecs[2].crc = 8'h07;
        vecs[3].n = 1; vecs[3].b[0] = 8'h00; vecs[3].crc = 8'h00;
        // {01,00}: crc after 0x01 is 0x07, and 0x07 through 8 shifts gives 0x15.
        vecs[4].n = 2; vecs[4].b[0] = 8'h01; vecs[4].b[1] = 8'h00; vecs[4].crc = 8'h15;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
        bus.count_ready = 1'b1; bus.data_ready = 1'b1;

        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("rst_valids", {30'd0, bus.count_valid, bus.data_valid}, 32'd0);
            check("rst_err", {31'd0, bus.err_overflow}, 32'd0);
            check("rst_data", {16'd0, bus.count_data, bus.data_data}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", {31'd0, bus.in_ready}, 32'd1);

        for (int k = 0; k < 5; k++) begin
            push_frame(vecs[k].b, vecs[k].n);
            drain_fast(vecs[k]);
        end

        // Backpressure on both output channels.
        bp_exp[0] = 8'h02; bp_exp[1] = 8'h01; bp_exp[2] = 8'h00; bp_exp[3] = 8'h15;
        push_frame(vecs[4].b, vecs[4].n);
        idx = 0;
        for (int k = 0; k < 300 && idx < 4; k++) begin
            if (idx == 0) begin
                check("bp_count_valid", {31'd0, bus.count_valid}, 32'd1);
                check("bp_count_data", {24'd0, bus.count_data}, {24'd0, bp_exp[0]});
                check("bp_data_idle", {31'd0, bus.data_valid}, 32'd0);
            end else begin
                check("bp_data_valid", {31'd0, bus.data_valid}, 32'd1);
                check($sformatf("bp_data%0d", idx), {24'd0, bus.data_data}, {24'd0, bp_exp[idx]});
            end
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            cr = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            bus.count_ready = cr;
            bus.data_ready  = dr;
            if (idx == 0 && cr) idx = 1;
            else if (idx > 0 && dr) idx++;
            @(negedge clk);
        end
        check("bp_all_transferred", idx, 32'd4);
        check("bp_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        bus.count_ready = 1'b1;
        bus.data_ready  = 1'b1;

        // 20-byte frame overflows at byte 17 and must emit nothing.
        begin
            vec_t big;
            big.n = 20; big.crc = 8'h00;
            for (int i = 0; i < 20; i++) big.b[i] = 8'(i + 8'h10);
            #3 emit_cnt = 0; err_cnt = 0;
            @(negedge clk);
            push_frame(big.b, big.n);
        end
        repeat (3) @(negedge clk);
        check("ovf_pulse_count", err_cnt, 32'd1);
        check("ovf_pulse_cycle", err_cyc, acc_cyc[16]);
        check("ovf_no_emit", emit_cnt, 32'd0);
        check("ovf_in_ready", {31'd0, bus.in_ready}, 32'd1);
        push_frame(vecs[2].b, vecs[2].n);
        drain_fast(vecs[2]);

        // Reset asserted while payload bytes are being sent.
        begin
            vec_t five;
            five.n = 5; five.crc = 8'h00;
            for (int i = 0; i < 5; i++) five.b[i] = 8'hA0 + 8'(i);
            push_frame(five.b, five.n);
        end
        repeat (2) @(negedge clk);
        check("mid_data_valid", {31'd0, bus.data_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
        check("mid_rst_count_valid", {31'd0, bus.count_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        emit_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_no_emit", emit_cnt, 32'd0);
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        push_frame(vecs[0].b, vecs[0].n);
        drain_fast(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
